gmsk_burst_framer: RTL

Upstream feeder for the GMSK modulator. Pulls payload bits over a valid/ready handshake and frames them into a GSM normal-burst bit sequence: head tail bits, payload, trailing tail bits, then guard bits. Applies GSM differential encoding and drives `input_bit` / `input_bit_strobe` at symbol rate, with the symbol period counted in `clk_en` ticks.

---
 rtl/gmsk_pkg.sv | 18 +
 rtl/gmsk_burst_framer_if.sv | 20 ++
 rtl/gmsk_symbol_timer.sv | 36 +++
 rtl/gmsk_burst_framer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/gmsk_pkg.sv
// Shared GSM burst constants and framer state encoding, also consumed by the modulator.
package gmsk_pkg;

    localparam int unsigned SAMPLES_PER_SYMBOL = 128;
    localparam int unsigned TAIL_BITS          = 3;
    localparam int unsigned PAYLOAD_BITS       = 142;
    localparam int unsigned GUARD_BITS         = 8;
    localparam int unsigned BURST_BITS         = 2 * TAIL_BITS + PAYLOAD_BITS + GUARD_BITS;

    typedef enum logic [2:0] {
        StIdle,
        StHead,
        StPayload,
        StTail,
        StGuard
    } state_e;

endpackage

// File: rtl/gmsk_burst_framer_if.sv
// Payload bit stream from the upstream source into the burst framer.
interface gmsk_burst_framer_if;

    logic data_bit;
    logic data_valid;
    logic data_ready;

    modport master (
        output data_bit,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_bit,
        input  data_valid,
        output data_ready
    );

endinterface

// File: rtl/gmsk_symbol_timer.sv
// clk_en-gated modulo-N sample counter; tick marks the last sample of each symbol.
module gmsk_symbol_timer #(
    parameter int unsigned N = 128
) (
    input  logic clock,
    input  logic reset,
    input  logic clk_en,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] Last = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = clk_en && (cnt_q == Last);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else if (clk_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gmsk_burst_framer.sv
// Frames payload bits into a GSM normal burst (tail, payload, tail, guard) and
// differentially encodes them at symbol rate for the GMSK modulator.
module gmsk_burst_framer
    import gmsk_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_SYMBOL = gmsk_pkg::SAMPLES_PER_SYMBOL,
    parameter int unsigned TAIL_BITS          = gmsk_pkg::TAIL_BITS,
    parameter int unsigned PAYLOAD_BITS       = gmsk_pkg::PAYLOAD_BITS,
    parameter int unsigned GUARD_BITS         = gmsk_pkg::GUARD_BITS
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clk_en,
    input  logic                      burst_start,
    gmsk_burst_framer_if.slave        data_if,
    output logic                      input_bit,
    output logic                      input_bit_strobe,
    output logic                      burst_active,
    output logic                      burst_done,
    output logic                      underrun
);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       prev_raw_q, prev_raw_d;
    logic       in_bit_q, in_bit_d;
    logic       strobe_q, strobe_d;
    logic       done_q, done_d;
    logic       underrun_q, underrun_d;
    logic [7:0] len_last;
    logic       raw;
    logic       tick;
    logic       timer_clr;

    gmsk_symbol_timer #(
        .N (SAMPLES_PER_SYMBOL)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clk_en (clk_en),
        .clear  (timer_clr),
        .tick   (tick)
    );

    always_comb begin
        case (state_q)
            StPayload: len_last = 8'(PAYLOAD_BITS - 1);
            StGuard:   len_last = 8'(GUARD_BITS - 1);
            default:   len_last = 8'(TAIL_BITS - 1);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prev_raw_d = prev_raw_q;
        in_bit_d   = in_bit_q;
        strobe_d   = 1'b0;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        raw        = 1'b0;
        timer_clr  = 1'b0;

        if (state_q == StIdle) begin
            // done_q blocks a start that coincides with the final strobe of the previous burst
            if (burst_start && !done_q) begin
                state_d    = StHead;
                cnt_d      = 8'd0;
                prev_raw_d = 1'b1;
                underrun_d = 1'b0;
                timer_clr  = 1'b1;
            end
        end else if (tick) begin
            case (state_q)
                StPayload: raw = data_if.data_valid & data_if.data_bit;
                StGuard:   raw = 1'b1;
                default:   raw = 1'b0;
            endcase
            if (state_q == StPayload && !data_if.data_valid) begin
                underrun_d = 1'b1;
            end
            in_bit_d   = raw ^ prev_raw_q;
            prev_raw_d = raw;
            strobe_d   = 1'b1;

            if (cnt_q == len_last) begin
                cnt_d = 8'd0;
                case (state_q)
                    StHead:    state_d = StPayload;
                    StPayload: state_d = StTail;
                    StTail:    state_d = StGuard;
                    default: begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            prev_raw_q <= 1'b1;
            in_bit_q   <= 1'b0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_raw_q <= prev_raw_d;
            in_bit_q   <= in_bit_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign data_if.data_ready = (state_q == StPayload) && tick;
    assign input_bit          = in_bit_q;
    assign input_bit_strobe   = strobe_q;
    assign burst_active       = (state_q != StIdle);
    assign burst_done         = done_q;
    assign underrun           = underrun_q;

endmodule
